// File: rtl/shield_write_encryptor_rr.sv
// shield_write_encryptor_rr
// Write-path crypto engine: per-line CTR-mode encryption followed by a keyed
// tag over (output line || address || counter). NUM_AES pad cores are reused
// for ROUNDS = LINE_WIDTH/(128*NUM_AES) rounds. Block b of the line uses the
// pad for nonce {iv, counter} and block counter b, so the result does not
// depend on NUM_AES.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   enc_req_*  (val/rdy)        plaintext line, counter, iv, mode
//                               (00 enc+auth, 01 enc only, 10 auth only,
//                               11 bypass)
//   enc_resp_* (val/rdy)        output line
//   auth_req_* (val/rdy)        address and counter bound into the tag
//   auth_resp_* (val/rdy)       tag
//   busy                        high outside IDLE and ACCEPT
//   dbg_state                   current FSM state
// Handshakes: a transfer happens on a cycle where val and rdy are both high.
// A producer keeps val and its payload stable until that cycle. All enc_req_*
// and auth_req_* inputs are sampled on their transfer cycle.
// The pad core and the tag core are lightweight keyed mixing functions with
// the same handshake and latency behaviour as the real cipher blocks.

module shield_aes_pad_core #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_val,
  output logic         req_rdy,
  input  logic [95:0]  nonce,
  input  logic [31:0]  blk,
  output logic         pad_val,
  input  logic         pad_rdy,
  output logic [127:0] pad
);
  localparam logic [127:0] PAD_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  logic         busy_q, busy_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [127:0] pad_q, pad_d;
  logic [127:0] blk_in;
  logic [31:0]  whiten;

  assign blk_in  = {nonce, blk};
  assign whiten  = blk * 32'h9e37_79b9;
  assign req_rdy = !busy_q;
  assign pad_val = busy_q && (cnt_q == 8'd0);
  assign pad     = pad_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pad_d  = pad_q;
    if (req_val && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = 8'(LATENCY);
      pad_d  = {blk_in[95:0], blk_in[127:96]} ^ PAD_KEY ^ {4{whiten}};
    end else if (busy_q) begin
      if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      else if (pad_rdy) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 8'd0;
      pad_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      pad_q  <= pad_d;
    end
  end
endmodule

module shield_hmac_core #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int CTR_WIDTH  = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [LINE_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [CTR_WIDTH-1:0]  counter,
  output logic                  tag_val,
  input  logic                  tag_rdy,
  output logic [127:0]          tag
);
  localparam logic [127:0] MAC_KEY = 128'h6a09e667_bb67ae85_3c6ef372_a54ff53a;
  localparam int CHUNKS = LINE_WIDTH / 128;

  logic         busy_q, busy_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [127:0] tag_q, tag_d;
  logic [127:0] acc;

  // Rotate-and-add chain over the 128-bit words of data, then {addr,counter}.
  always_comb begin
    acc = MAC_KEY;
    for (int c = 0; c < CHUNKS; c++)
      acc = {acc[122:0], acc[127:123]} + data[c*128 +: 128];
    acc = {acc[122:0], acc[127:123]} + 128'({addr, counter});
    acc = acc ^ MAC_KEY;
  end

  assign req_rdy = !busy_q;
  assign tag_val = busy_q && (cnt_q == 8'd0);
  assign tag     = tag_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    tag_d  = tag_q;
    if (req_val && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = 8'(LATENCY);
      tag_d  = acc;
    end else if (busy_q) begin
      if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      else if (tag_rdy) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 8'd0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
    end
  end
endmodule

module shield_write_encryptor_rr #(
  parameter int SHIELD_ADDR_WIDTH    = 32,
  parameter int SHIELD_COUNTER_WIDTH = 32,
  parameter int LINE_WIDTH           = 512,
  parameter int HMAC_TAG_WIDTH       = 128,
  parameter int NUM_AES              = 2,
  parameter int AES_LATENCY          = 1,
  parameter int HMAC_LATENCY         = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [LINE_WIDTH-1:0]           enc_req_data,
  input  logic [SHIELD_COUNTER_WIDTH-1:0] enc_req_counter,
  input  logic [63:0]                     enc_req_iv,
  input  logic [1:0]                      enc_req_mode,
  input  logic                            enc_req_val,
  output logic                            enc_req_rdy,
  output logic [LINE_WIDTH-1:0]           enc_resp_data,
  output logic                            enc_resp_val,
  input  logic                            enc_resp_rdy,
  input  logic [SHIELD_COUNTER_WIDTH-1:0] auth_req_counter,
  input  logic [SHIELD_ADDR_WIDTH-1:0]    auth_req_addr,
  input  logic                            auth_req_val,
  output logic                            auth_req_rdy,
  output logic [HMAC_TAG_WIDTH-1:0]       auth_resp_tag,
  output logic                            auth_resp_val,
  input  logic                            auth_resp_rdy,
  output logic                            busy,
  output logic [2:0]                      dbg_state
);
  localparam int CHUNKS = LINE_WIDTH / 128;
  localparam int ROUNDS = CHUNKS / NUM_AES;
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int BW     = $clog2(LINE_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ACCEPT, PAD_REQ, PAD_WAIT, RESP, AUTH_REQ, AUTH_RESP
  } state_t;

  state_t                          state_q, state_d;
  logic [RW-1:0]                   round_q, round_d;
  logic [NUM_AES-1:0]              issued_q, issued_d;
  logic [LINE_WIDTH-1:0]           out_q, out_d;
  logic [SHIELD_COUNTER_WIDTH-1:0] ctr_q, ctr_d;
  logic [63:0]                     iv_q, iv_d;
  logic [1:0]                      mode_q, mode_d;

  logic [NUM_AES-1:0] aes_req_val, aes_req_rdy, aes_pad_val, aes_pad_rdy;
  logic [127:0]       aes_pad [NUM_AES];
  logic [31:0]        ctr32;
  logic [BW-1:0]      base;
  logic               hmac_req_val, hmac_req_rdy, hmac_tag_val, hmac_tag_rdy;
  logic [127:0]       hmac_tag;

  assign ctr32 = 32'(ctr_q);

  for (genvar g = 0; g < NUM_AES; g++) begin : g_aes
    logic [31:0] blk;
    assign blk            = 32'(round_q) * 32'(NUM_AES) + 32'(g);
    assign aes_req_val[g] = (state_q == PAD_REQ) && !issued_q[g];
    assign aes_pad_rdy[g] = (state_q == PAD_WAIT) && (&aes_pad_val);
    shield_aes_pad_core #(.LATENCY(AES_LATENCY)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_val (aes_req_val[g]),
      .req_rdy (aes_req_rdy[g]),
      .nonce   ({iv_q, ctr32}),
      .blk     (blk),
      .pad_val (aes_pad_val[g]),
      .pad_rdy (aes_pad_rdy[g]),
      .pad     (aes_pad[g])
    );
  end

  assign hmac_req_val = (state_q == AUTH_REQ) && auth_req_val;
  assign hmac_tag_rdy = (state_q == AUTH_RESP) && auth_resp_rdy;

  shield_hmac_core #(
    .LINE_WIDTH (LINE_WIDTH),
    .ADDR_WIDTH (SHIELD_ADDR_WIDTH),
    .CTR_WIDTH  (SHIELD_COUNTER_WIDTH),
    .LATENCY    (HMAC_LATENCY)
  ) u_hmac (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_val (hmac_req_val),
    .req_rdy (hmac_req_rdy),
    .data    (out_q),
    .addr    (auth_req_addr),
    .counter (auth_req_counter),
    .tag_val (hmac_tag_val),
    .tag_rdy (hmac_tag_rdy),
    .tag     (hmac_tag)
  );

  assign enc_req_rdy   = (state_q == ACCEPT);
  assign enc_resp_val  = (state_q == RESP);
  assign enc_resp_data = out_q;
  assign auth_req_rdy  = (state_q == AUTH_REQ) && hmac_req_rdy;
  assign auth_resp_val = (state_q == AUTH_RESP) && hmac_tag_val;
  assign auth_resp_tag = hmac_tag[HMAC_TAG_WIDTH-1:0];
  assign busy          = (state_q != IDLE) && (state_q != ACCEPT);
  assign dbg_state     = state_q;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    issued_d = issued_q;
    out_d    = out_q;
    ctr_d    = ctr_q;
    iv_d     = iv_q;
    mode_d   = mode_q;
    base     = '0;
    case (state_q)
      IDLE: if (&aes_req_rdy) state_d = ACCEPT;
      ACCEPT: if (enc_req_val) begin
        out_d    = enc_req_data;  // preloaded so pads XOR in place
        ctr_d    = enc_req_counter;
        iv_d     = enc_req_iv;
        mode_d   = enc_req_mode;
        round_d  = '0;
        issued_d = '0;
        state_d  = enc_req_mode[1] ? RESP : PAD_REQ;
      end
      PAD_REQ: begin
        // Cores may accept on different cycles; never re-issue an accepted one.
        issued_d = issued_q | (aes_req_val & aes_req_rdy);
        if (&issued_d) begin
          issued_d = '0;
          state_d  = PAD_WAIT;
        end
      end
      PAD_WAIT: if (&aes_pad_val) begin
        for (int i = 0; i < NUM_AES; i++) begin
          base = BW'((int'(round_q) * NUM_AES + i) * 128);
          out_d[base +: 128] = out_q[base +: 128] ^ aes_pad[i];
        end
        if (round_q == RW'(ROUNDS - 1)) state_d = RESP;
        else begin
          round_d = round_q + RW'(1);
          state_d = PAD_REQ;
        end
      end
      RESP: if (enc_resp_rdy) state_d = mode_q[0] ? IDLE : AUTH_REQ;
      AUTH_REQ: if (auth_req_val && hmac_req_rdy) state_d = AUTH_RESP;
      AUTH_RESP: if (hmac_tag_val && auth_resp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= '0;
      issued_q <= '0;
      out_q    <= '0;
      ctr_q    <= '0;
      iv_q     <= '0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      issued_q <= issued_d;
      out_q    <= out_d;
      ctr_q    <= ctr_d;
      iv_q     <= iv_d;
      mode_q   <= mode_d;
    end
  end
endmodule

// File: tb/tb_shield_write_encryptor_rr.sv
// Bench for shield_write_encryptor_rr: directed scenarios plus random lines,
// checked against a line-level model of the pad and tag functions.
module tb_shield_write_encryptor_rr;
  localparam int LW      = 512;
  localparam int NA      = 2;
  localparam int TW      = 128;
  localparam int AES_LAT = 1;
  localparam int CH      = LW / 128;
  localparam int RND     = CH / NA;
  localparam logic [2:0] S_IDLE = 3'd0, S_ACCEPT = 3'd1, S_PAD_WAIT = 3'd3;
  localparam logic [127:0] PAD_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] MAC_KEY = 128'h6a09e667_bb67ae85_3c6ef372_a54ff53a;

  logic          clk = 0, rst_n = 0;
  logic [LW-1:0] enc_req_data = '0;
  logic [31:0]   enc_req_counter = '0;
  logic [63:0]   enc_req_iv = '0;
  logic [1:0]    enc_req_mode = '0;
  logic          enc_req_val = 0, enc_req_rdy;
  logic [LW-1:0] enc_resp_data;
  logic          enc_resp_val, enc_resp_rdy = 0;
  logic [31:0]   auth_req_counter = '0, auth_req_addr = '0;
  logic          auth_req_val = 0, auth_req_rdy;
  logic [TW-1:0] auth_resp_tag;
  logic          auth_resp_val, auth_resp_rdy = 0;
  logic          busy;
  logic [2:0]    dbg_state;

  int checks = 0, errors = 0;
  logic [LW-1:0] exp_q[$];

  shield_write_encryptor_rr #(
    .SHIELD_ADDR_WIDTH(32), .SHIELD_COUNTER_WIDTH(32), .LINE_WIDTH(LW),
    .HMAC_TAG_WIDTH(TW), .NUM_AES(NA), .AES_LATENCY(AES_LAT), .HMAC_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_req_data(enc_req_data), .enc_req_counter(enc_req_counter),
    .enc_req_iv(enc_req_iv), .enc_req_mode(enc_req_mode),
    .enc_req_val(enc_req_val), .enc_req_rdy(enc_req_rdy),
    .enc_resp_data(enc_resp_data), .enc_resp_val(enc_resp_val), .enc_resp_rdy(enc_resp_rdy),
    .auth_req_counter(auth_req_counter), .auth_req_addr(auth_req_addr),
    .auth_req_val(auth_req_val), .auth_req_rdy(auth_req_rdy),
    .auth_resp_tag(auth_resp_tag), .auth_resp_val(auth_resp_val), .auth_resp_rdy(auth_resp_rdy),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: keystream block b is the keyed whitening of {iv,ctr,b}.
  function automatic logic [127:0] pad_model(input logic [63:0] iv, input logic [31:0] ctr,
                                             input int b);
    logic [127:0] x;
    logic [31:0]  w;
    x = {iv, ctr, 32'(b)};
    w = 32'(b) * 32'h9e37_79b9;
    return ((x << 32) | (x >> 96)) ^ PAD_KEY ^ {w, w, w, w};
  endfunction

  function automatic logic [127:0] tag_model(input logic [LW-1:0] line, input logic [31:0] addr,
                                             input logic [31:0] ctr);
    logic [127:0] acc;
    logic [127:0] words[CH+1];
    for (int c = 0; c < CH; c++) words[c] = line[c*128 +: 128];
    words[CH] = {64'd0, addr, ctr};
    acc = MAC_KEY;
    foreach (words[k]) acc = ((acc << 5) | (acc >> 123)) + words[k];
    return acc ^ MAC_KEY;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Drives one full line through the engine and checks every observable step.
  task automatic do_line(input logic [LW-1:0] pt, input logic [31:0] ctr, input logic [63:0] iv,
                         input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] actr,
                         input int resp_hold, input int tag_hold);
    logic [LW-1:0] exp_line, exp_now;
    logic [TW-1:0] exp_tag;
    int lat, exp_lat, w;
    bit ok;
    exp_line = pt;
    if (!mode[1])
      for (int b = 0; b < CH; b++) exp_line[b*128 +: 128] = pt[b*128 +: 128] ^ pad_model(iv, ctr, b);
    exp_q.push_back(exp_line);
    @(negedge clk);
    enc_req_data = pt; enc_req_counter = ctr; enc_req_iv = iv; enc_req_mode = mode;
    enc_req_val = 1;
    w = 0;
    while (!enc_req_rdy && w < 50) begin @(negedge clk); w++; end
    checks++;
    if (enc_req_rdy !== 1'b1) begin
      errors++; $display("FAIL req_accept: rdy=%b required 1", enc_req_rdy);
      enc_req_val = 0; void'(exp_q.pop_back()); return;
    end
    @(negedge clk);
    enc_req_val = 0;
    lat = 1;
    exp_lat = mode[1] ? 1 : RND * (2 + AES_LAT) + 1;
    while (enc_resp_val !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (enc_resp_val !== 1'b1 || lat != exp_lat) begin
      errors++; $display("FAIL resp_latency: got %0d val=%b required %0d", lat, enc_resp_val, exp_lat);
      if (enc_resp_val !== 1'b1) begin void'(exp_q.pop_back()); return; end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_resp: got %b required 1", busy); end
    exp_now = exp_q.pop_front();
    ok = 1;
    for (int i = 0; i < resp_hold; i++) begin
      if (enc_resp_val !== 1'b1 || enc_resp_data !== exp_now) ok = 0;
      @(negedge clk);
    end
    if (resp_hold > 0) begin
      checks++;
      if (!ok) begin errors++; $display("FAIL resp_hold_stable: data/val changed under backpressure (required stable)"); end
    end
    checks++;
    if (enc_resp_data !== exp_now) begin
      errors++; $display("FAIL resp_data mode=%0d: got %h required %h", mode, enc_resp_data, exp_now);
    end
    enc_resp_rdy = 1;
    @(negedge clk);
    enc_resp_rdy = 0;
    if (!mode[0]) begin
      exp_tag = TW'(tag_model(exp_now, addr, actr));
      auth_req_addr = addr; auth_req_counter = actr; auth_req_val = 1;
      w = 0;
      while (!auth_req_rdy && w < 20) begin @(negedge clk); w++; end
      checks++;
      if (auth_req_rdy !== 1'b1) begin
        errors++; $display("FAIL auth_req_rdy: got %b required 1", auth_req_rdy);
        auth_req_val = 0; return;
      end
      @(negedge clk);
      auth_req_val = 0; auth_req_addr = $urandom; auth_req_counter = $urandom;
      w = 0;
      while (!auth_resp_val && w < 50) begin @(negedge clk); w++; end
      ok = 1;
      for (int i = 0; i < tag_hold; i++) begin
        if (auth_resp_val !== 1'b1 || auth_resp_tag !== exp_tag) ok = 0;
        @(negedge clk);
      end
      if (tag_hold > 0) begin
        checks++;
        if (!ok) begin errors++; $display("FAIL tag_hold_stable: tag/val changed under backpressure (required stable)"); end
      end
      checks++;
      if (auth_resp_val !== 1'b1 || auth_resp_tag !== exp_tag) begin
        errors++; $display("FAIL auth_tag mode=%0d: val=%b got %h required %h", mode, auth_resp_val, auth_resp_tag, exp_tag);
      end
      auth_resp_rdy = 1;
      @(negedge clk);
      auth_resp_rdy = 0;
    end else begin
      // No tag path for ENC_ONLY / BYPASS: a stray auth request must be ignored.
      auth_req_val = 1; ok = 1;
      repeat (5) begin
        if (auth_req_rdy !== 1'b0 || auth_resp_val !== 1'b0) ok = 0;
        @(negedge clk);
      end
      auth_req_val = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL no_tag_path: auth rdy/val seen, required 0"); end
    end
    checks++;
    if (dbg_state !== S_IDLE && dbg_state !== S_ACCEPT) begin
      errors++; $display("FAIL back_to_idle: state=%0d required IDLE/ACCEPT", dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (enc_req_rdy !== 0 || enc_resp_val !== 0 || auth_req_rdy !== 0 || auth_resp_val !== 0 ||
        busy !== 0 || dbg_state !== S_IDLE || enc_resp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b ar=%b av=%b busy=%b st=%0d required all 0",
               enc_req_rdy, enc_resp_val, auth_req_rdy, auth_resp_val, busy, dbg_state);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (enc_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_to_accept: rdy=%b required 1", enc_req_rdy); end
  endtask

  task automatic test_directed();
    logic [LW-1:0] l;
    do_line('0, 32'd5, 64'h1, 2'b00, 32'h1000, 32'd5, 0, 0);
    for (int i = 0; i < LW / 8; i++) l[i*8 +: 8] = 8'ha5;
    do_line(l, $urandom, $urandom, 2'b11, 32'h2000, 32'd9, 0, 0);
    do_line(LW'(16'h1234), 32'd7, 64'hdead, 2'b10, 32'h1000, 32'd5, 0, 0);
    do_line(rand_line(), 32'd3, 64'hcafe, 2'b01, 32'h0, 32'd0, 0, 0);
  endtask

  task automatic test_backpressure();
    do_line(rand_line(), $urandom, {$urandom, $urandom}, 2'b00, $urandom, $urandom, 50, 20);
  endtask

  task automatic test_reset_midop();
    int w;
    @(negedge clk);
    enc_req_data = rand_line(); enc_req_counter = 32'd11; enc_req_iv = 64'h77; enc_req_mode = 2'b00;
    enc_req_val = 1;
    w = 0;
    while (!enc_req_rdy && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    enc_req_val = 0;
    repeat (4) @(negedge clk);  // second round's pad wait
    checks++;
    if (dbg_state !== S_PAD_WAIT) begin errors++; $display("FAIL midop_state: got %0d required %0d", dbg_state, S_PAD_WAIT); end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (enc_req_rdy !== 0 || enc_resp_val !== 0 || auth_req_rdy !== 0 || auth_resp_val !== 0 ||
        busy !== 0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL midop_reset: rv=%b av=%b busy=%b st=%0d required 0/IDLE",
                         enc_resp_val, auth_resp_val, busy, dbg_state);
    end
    rst_n = 1;
    do_line(rand_line(), 32'd12, 64'h78, 2'b00, 32'h40, 32'd12, 1, 1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++)
      do_line(rand_line(), $urandom, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
